prbs_checker: RTL and testbench
===============================

// Module: prbs_checker
// PURPOSE
// Receive-side partner of the team's 14-bit XNOR LFSR pattern generator. Takes one
// serial bit per valid cycle, self-synchronises a local LFSR to the incoming stream,
// declares lock, then flywheels and counts bit errors. Used on the far side of
// serial links and loopback paths for BER measurement.
// PARAMETERS
// WIDTH       14  LFSR length (bits)
// TAP_A       13  first feedback tap index
// TAP_B        3  second feedback tap index
// LOCK_COUNT  16  consecutive matches needed to declare lock (>=1)
// WINDOW      64  bits per loss-of-lock observation window
// ERR_THRESH   8  errors within one window that force loss of lock (1..WINDOW)
// CNT_W       32  width of bit/error counters
// PORTS
// clk        in   1      rising-edge clock
// reset      in   1      asynchronous, active-high reset
// in_valid   in   1      in_bit is valid this cycle
// in_bit     in   1      received serial bit
// clear      in   1      sync clear of bit_count/err_count (lock state untouched)
// locked     out  1      checker is in LOCKED
// error      out  1      one-cycle pulse: mismatch detected while LOCKED
// bit_count  out  CNT_W  valid bits checked while LOCKED (saturating)
// err_count  out  CNT_W  mismatches while LOCKED (saturating)
// BEHAVIOUR
// - Local register s[WIDTH-1:0]; pred = ~(s[TAP_A] ^ s[TAP_B]); shift = {s[WIDTH-2:0], b}.
//   Generator emits its new feedback bit each cycle; the checker compares against pred.
// - Reset (async): state=HUNT, s=0, fill=0, run=0, win=0, werr=0; all outputs 0.
// - in_valid=0: no state, register, or counter change; error=0.
// - HUNT: shift in_bit into s; fill++. On the WIDTH-th valid bit -> VERIFY.
// - VERIFY: compare in_bit to pred, then shift in_bit (self-sync).
//   match & s!=all-ones -> run++; run reaching LOCK_COUNT -> LOCKED (locked=1 same edge).
//   mismatch -> run=0, stay VERIFY. s==all-ones (XNOR lock-up/stuck-high) -> run=0.
//   Earliest locked = WIDTH+LOCK_COUNT valid bits after reset (30 by default).
// - LOCKED: shift pred (flywheel, not in_bit). bit_count++. mismatch -> error=1 next
//   cycle, err_count++, werr++. win++ per valid bit; win wraps to 0 after WINDOW bits,
//   and werr clears at the wrap.
//   werr reaching ERR_THRESH -> HUNT immediately: locked=0, fill=0, run=0, win=0, werr=0.
//   If a window-wrap and the ERR_THRESH-th error occur on the same bit, loss of lock wins.
// - Counters saturate at all-ones, never wrap. clear has priority over an increment in
//   the same cycle (result 0). Counters retain values across loss/regain of lock.
// - error, locked, and the counters are registered; no combinational input-to-output path.
// - reset asserted mid-stream: immediate return to reset values; resync from HUNT.
// TESTING
// 1. Generator seeded 0 (stream 1,1,1,1,0,...), in_valid=1 -> locked rises after bit 30;
//    500 further bits -> bit_count=500, err_count=0, error never pulses.
// 2. Locked; flip bits 100 and 140 -> two single-cycle error pulses, err_count=2,
//    locked stays 1.
// 3. Locked; flip 8 bits within one 64-bit window -> locked=0 on the 8th error, then
//    relock 30 valid bits later; err_count=8.
// 4. in_bit tied to 1 for 1000 cycles -> locked stays 0 (all-ones guard).
// 5. Valid stream with in_valid toggling 1/0 each cycle -> same lock point (30 valid bits)
//    and bit_count as scenario 1; no change on idle cycles.
// 6. Preload err_count near saturation (CNT_W=4): 20 errors -> err_count=15. Pulse clear
//    together with an error -> err_count=0. Assert reset mid-stream -> all outputs 0 at
//    once.

Source files
------------

// File: rtl/prbs_checker_if.sv
// Serial PRBS checker bus: bit stream in, lock/error status and BER counters out.
interface prbs_checker_if #(
  parameter int unsigned CNT_W = 32
);
  logic             in_valid;
  logic             in_bit;
  logic             clear;
  logic             locked;
  logic             error;
  logic [CNT_W-1:0] bit_count;
  logic [CNT_W-1:0] err_count;

  modport master (
    output in_valid, in_bit, clear,
    input  locked, error, bit_count, err_count
  );

  modport slave (
    input  in_valid, in_bit, clear,
    output locked, error, bit_count, err_count
  );
endinterface

// File: rtl/prbs_checker.sv
// Self-synchronising checker for the 14-bit XNOR LFSR pattern generator: hunts, verifies,
// locks, then flywheels the local LFSR and counts bit errors with windowed loss-of-lock.
module prbs_checker #(
  parameter int unsigned WIDTH      = 14,
  parameter int unsigned TAP_A      = 13,
  parameter int unsigned TAP_B      = 3,
  parameter int unsigned LOCK_COUNT = 16,
  parameter int unsigned WINDOW     = 64,
  parameter int unsigned ERR_THRESH = 8,
  parameter int unsigned CNT_W      = 32
) (
  input logic           clk,
  input logic           reset,
  prbs_checker_if.slave bus
);

  localparam logic [1:0] StHunt   = 2'd0;
  localparam logic [1:0] StVerify = 2'd1;
  localparam logic [1:0] StLocked = 2'd2;

  localparam int unsigned FillW = $clog2(WIDTH + 1);
  localparam int unsigned RunW  = $clog2(LOCK_COUNT + 1);
  localparam int unsigned WinW  = $clog2(WINDOW + 1);
  localparam int unsigned WerrW = $clog2(ERR_THRESH + 1);

  localparam logic [FillW-1:0] FillLast = FillW'(WIDTH - 1);
  localparam logic [RunW-1:0]  RunLast  = RunW'(LOCK_COUNT - 1);
  localparam logic [WinW-1:0]  WinLast  = WinW'(WINDOW - 1);
  localparam logic [WerrW-1:0] WerrLast = WerrW'(ERR_THRESH - 1);
  localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [FillW-1:0] fill_q, fill_d;
  logic [RunW-1:0]  run_q, run_d;
  logic [WinW-1:0]  win_q, win_d;
  logic [WerrW-1:0] werr_q, werr_d;
  logic             error_q, error_d;
  logic [CNT_W-1:0] bit_count_q, bit_count_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;

  logic pred;
  logic mismatch;

  assign pred     = ~(s_q[TAP_A] ^ s_q[TAP_B]);
  assign mismatch = bus.in_bit ^ pred;

  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    fill_d      = fill_q;
    run_d       = run_q;
    win_d       = win_q;
    werr_d      = werr_q;
    error_d     = 1'b0;
    bit_count_d = bit_count_q;
    err_count_d = err_count_q;

    if (bus.in_valid) begin
      unique case (state_q)
        StHunt: begin
          s_d = {s_q[WIDTH-2:0], bus.in_bit};
          if (fill_q == FillLast) begin
            state_d = StVerify;
            fill_d  = '0;
          end else begin
            fill_d = fill_q + FillW'(1);
          end
        end
        StVerify: begin
          s_d = {s_q[WIDTH-2:0], bus.in_bit};
          // All-ones is the XNOR lock-up state: a stuck-high line would match forever.
          if (s_q == '1 || mismatch) begin
            run_d = '0;
          end else if (run_q == RunLast) begin
            state_d = StLocked;
            run_d   = '0;
          end else begin
            run_d = run_q + RunW'(1);
          end
        end
        StLocked: begin
          s_d         = {s_q[WIDTH-2:0], pred};
          bit_count_d = (bit_count_q == '1) ? bit_count_q : bit_count_q + CntOne;
          if (mismatch) begin
            error_d     = 1'b1;
            err_count_d = (err_count_q == '1) ? err_count_q : err_count_q + CntOne;
            werr_d      = werr_q + WerrW'(1);
          end
          // Threshold check first so loss of lock beats a coincident window wrap.
          if (mismatch && werr_q == WerrLast) begin
            state_d = StHunt;
            fill_d  = '0;
            run_d   = '0;
            win_d   = '0;
            werr_d  = '0;
          end else if (win_q == WinLast) begin
            win_d  = '0;
            werr_d = '0;
          end else begin
            win_d = win_q + WinW'(1);
          end
        end
        default: state_d = StHunt;
      endcase
    end

    if (bus.clear) begin
      bit_count_d = '0;
      err_count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StHunt;
      s_q         <= '0;
      fill_q      <= '0;
      run_q       <= '0;
      win_q       <= '0;
      werr_q      <= '0;
      error_q     <= 1'b0;
      bit_count_q <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      fill_q      <= fill_d;
      run_q       <= run_d;
      win_q       <= win_d;
      werr_q      <= werr_d;
      error_q     <= error_d;
      bit_count_q <= bit_count_d;
      err_count_q <= err_count_d;
    end
  end

  assign bus.locked    = (state_q == StLocked);
  assign bus.error     = error_q;
  assign bus.bit_count = bit_count_q;
  assign bus.err_count = err_count_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker: two instances (32-bit and 4-bit counters) share one stimulus
// stream and are compared each cycle against a queue-based model of the checker rules.
module tb_prbs_checker;
  localparam int W   = 14;
  localparam int TA  = 13;
  localparam int TB  = 3;
  localparam int LC  = 16;
  localparam int WIN = 64;
  localparam int THR = 8;

  logic clk = 1'b0;
  logic reset;

  prbs_checker_if #(.CNT_W(32)) bus_a ();
  prbs_checker_if #(.CNT_W(4))  bus_b ();

  prbs_checker #(.CNT_W(32)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  prbs_checker #(.CNT_W(4))  dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  // Reference model: history queue (newest first), mode 0=hunt 1=verify 2=locked.
  bit     hist[$];
  int     m_mode, m_fill, m_run, m_win, m_werr;
  longint m_bits, m_errs;
  bit     m_error;
  logic [13:0] g;

  typedef struct {
    int     nbits;
    bit     locked;
    longint bits;
    longint errs;
  } vec_t;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic longint sat(input longint x, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (x > mx) ? mx : x;
  endfunction

  task automatic push(input bit x);
    hist.push_front(x);
    void'(hist.pop_back());
  endtask

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < W; i++) hist.push_back(1'b0);
    m_mode = 0; m_fill = 0; m_run = 0; m_win = 0; m_werr = 0;
    m_bits = 0; m_errs = 0; m_error = 1'b0;
  endtask

  task automatic model_step(input bit v, input bit b, input bit c);
    bit p, ones;
    m_error = 1'b0;
    if (v) begin
      p = !(hist[TA] ^ hist[TB]);
      ones = 1'b1;
      foreach (hist[i]) if (!hist[i]) ones = 1'b0;
      case (m_mode)
        0: begin
          push(b);
          m_fill++;
          if (m_fill == W) begin m_mode = 1; m_fill = 0; end
        end
        1: begin
          push(b);
          if (ones || b != p) m_run = 0;
          else begin
            m_run++;
            if (m_run == LC) begin m_mode = 2; m_run = 0; end
          end
        end
        default: begin
          push(p);
          m_bits++;
          m_win++;
          if (b != p) begin m_error = 1'b1; m_errs++; m_werr++; end
          if (m_werr == THR) begin
            m_mode = 0; m_fill = 0; m_run = 0; m_win = 0; m_werr = 0;
          end else if (m_win == WIN) begin
            m_win = 0; m_werr = 0;
          end
        end
      endcase
    end
    if (c) begin m_bits = 0; m_errs = 0; end
  endtask

  task automatic compare_all();
    check("locked_a", bus_a.locked, 64'(m_mode == 2));
    check("locked_b", bus_b.locked, 64'(m_mode == 2));
    check("error_a", bus_a.error, 64'(m_error));
    check("error_b", bus_b.error, 64'(m_error));
    check("bit_count_a", bus_a.bit_count, 64'(sat(m_bits, 32)));
    check("err_count_a", bus_a.err_count, 64'(sat(m_errs, 32)));
    check("bit_count_b", bus_b.bit_count, 64'(sat(m_bits, 4)));
    check("err_count_b", bus_b.err_count, 64'(sat(m_errs, 4)));
  endtask

  task automatic step(input bit v, input bit b, input bit c);
    bus_a.in_valid = v; bus_a.in_bit = b; bus_a.clear = c;
    bus_b.in_valid = v; bus_b.in_bit = b; bus_b.clear = c;
    @(posedge clk);
    #1;
    model_step(v, b, c);
    compare_all();
    if (bus_a.error === 1'b1) pulses++;
  endtask

  task automatic gen_bit(output bit b);
    b = ~(g[TA] ^ g[TB]);
    g = {g[12:0], b};
  endtask

  // Generator advances only on valid cycles; flip injects a bit error.
  task automatic send(input bit v, input bit flip, input bit c);
    bit b;
    if (v) begin
      gen_bit(b);
      step(1'b1, b ^ flip, c);
    end else begin
      step(1'b0, 1'($urandom), c);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    g = '0;
    #2;
    check("rst_locked", bus_a.locked, 64'd0);
    check("rst_error", bus_a.error, 64'd0);
    check("rst_bit_count", bus_a.bit_count, 64'd0);
    check("rst_err_count", bus_a.err_count, 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    vec_t tbl[4];
    int   sent;
    int   vcount;
    bit   ever_locked;
    bit   v;

    tbl[0] = '{nbits: 29,  locked: 1'b0, bits: 0,   errs: 0};
    tbl[1] = '{nbits: 30,  locked: 1'b1, bits: 0,   errs: 0};
    tbl[2] = '{nbits: 31,  locked: 1'b1, bits: 1,   errs: 0};
    tbl[3] = '{nbits: 530, locked: 1'b1, bits: 500, errs: 0};

    reset = 1'b1;
    bus_a.in_valid = 1'b0; bus_a.in_bit = 1'b0; bus_a.clear = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.in_bit = 1'b0; bus_b.clear = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Clean stream from seed 0: lock point and locked bit count.
    sent = 0;
    pulses = 0;
    foreach (tbl[k]) begin
      while (sent < tbl[k].nbits) begin
        send(1'b1, 1'b0, 1'b0);
        sent++;
      end
      check("tbl_locked", bus_a.locked, 64'(tbl[k].locked));
      check("tbl_bit_count", bus_a.bit_count, 64'(tbl[k].bits));
      check("tbl_err_count", bus_a.err_count, 64'(tbl[k].errs));
    end
    check("clean_pulses", 64'(pulses), 64'd0);
    check("sat_bit_count_b", bus_b.bit_count, 64'd15);

    // Two isolated errors while locked.
    pulses = 0;
    for (int i = 0; i < 200; i++) send(1'b1, (i == 100 || i == 140), 1'b0);
    check("two_err_pulses", 64'(pulses), 64'd2);
    check("two_err_count", bus_a.err_count, 64'd2);
    check("two_err_locked", bus_a.locked, 64'd1);

    // Eight errors inside one window force loss of lock, then relock after 30 bits.
    send(1'b0, 1'b0, 1'b1);
    check("clear_idle", bus_a.err_count, 64'd0);
    for (int i = 0; i <= 24; i++) begin
      send(1'b1, (i >= 10 && i % 2 == 0), 1'b0);
      if (i == 23) check("pre_loss_locked", bus_a.locked, 64'd1);
      if (i == 24) check("loss_locked", bus_a.locked, 64'd0);
    end
    check("loss_err_count", bus_a.err_count, 64'd8);
    for (int j = 1; j <= 30; j++) begin
      send(1'b1, 1'b0, 1'b0);
      if (j == 29) check("relock_early", bus_a.locked, 64'd0);
      if (j == 30) check("relock", bus_a.locked, 64'd1);
    end

    // Stuck-high line must never lock.
    do_reset();
    ever_locked = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      step(1'b1, 1'b1, 1'b0);
      if (bus_a.locked === 1'b1) ever_locked = 1'b1;
    end
    check("stuck_high_lock", 64'(ever_locked), 64'd0);

    // Valid toggling every cycle: lock still at 30 valid bits.
    do_reset();
    vcount = 0;
    for (int c = 0; vcount < 530; c++) begin
      v = (c % 2 == 0);
      send(v, 1'b0, 1'b0);
      if (v) begin
        vcount++;
        if (vcount == 29) check("toggle_prelock", bus_a.locked, 64'd0);
        if (vcount == 30) check("toggle_lock", bus_a.locked, 64'd1);
      end
    end
    check("toggle_bit_count", bus_a.bit_count, 64'd500);

    // 20 spread errors saturate the 4-bit error counter; clear beats a coincident error.
    send(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 240; i++) send(1'b1, (i % 12 == 11), 1'b0);
    check("sat_err_b", bus_b.err_count, 64'd15);
    check("sat_err_a", bus_a.err_count, 64'd20);
    check("sat_locked", bus_a.locked, 64'd1);
    send(1'b1, 1'b1, 1'b1);
    check("clear_vs_err_a", bus_a.err_count, 64'd0);
    check("clear_vs_err_b", bus_b.err_count, 64'd0);
    check("clear_vs_err_pulse", bus_a.error, 64'd1);
    for (int i = 0; i < 5; i++) send(1'b1, 1'b0, 1'b0);
    do_reset();

    // Randomised traffic with sparse errors, clears and occasional mid-stream resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 999) == 0) do_reset();
      send($urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0, $urandom_range(0, 199) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
